// File: rtl/sram22_req_ctrl_if.sv
// Request/response handshake bundle between the system bus and sram22_req_ctrl.
// The master drives requests and consumes responses; the controller is the slave.
interface sram22_req_ctrl_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [WMASK_WIDTH-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_WIDTH-1:0]  resp_rdata;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram22_req_ctrl.sv
// Request-side controller for the SRAM22 byte-masked macro: zero-fills the array
// after reset, forwards bus requests to the macro and queues read data (2 deep).
module sram22_req_ctrl #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int WMASK_WIDTH   = 4,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram22_req_ctrl_if.slave       bus,
  output logic                   init_done,
  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);
  localparam logic [1:0] ST_RST_WAIT = 2'd0;
  localparam logic [1:0] ST_INIT     = 2'd1;
  localparam logic [1:0] ST_IDLE     = 2'd2;

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic                  rd_pending_r;
  logic [1:0]            q_count_r;
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [DATA_WIDTH-1:0] q_mem_r [0:1];
  logic                  credit_s;
  logic                  rd_fire_s;
  logic                  pop_s;

  // Macro reset pin: released on the first edge after rst drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_rstb <= 1'b0;
    end else begin
      sram_rstb <= 1'b1;
    end
  end

  // Sequencer: one wait cycle, optional zero-fill walk, then service requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RST_WAIT;
      init_cnt_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_RST_WAIT: state_r <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (init_cnt_r == {ADDR_WIDTH{1'b1}}) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_IDLE: state_r <= ST_IDLE;
        default: state_r <= ST_RST_WAIT;
      endcase
    end
  end

  // Macro pin mux and request acceptance; a read needs a free response slot
  always_comb begin
    credit_s      = ({1'b0, q_count_r} + {2'b00, rd_pending_r}) < 3'd2;
    bus.req_ready = 1'b0;
    sram_ce       = 1'b0;
    sram_we       = 1'b0;
    sram_wmask    = {WMASK_WIDTH{1'b0}};
    sram_addr     = {ADDR_WIDTH{1'b0}};
    sram_din      = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_INIT: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_wmask = {WMASK_WIDTH{1'b1}};
        sram_addr  = init_cnt_r;
      end
      ST_IDLE: begin
        bus.req_ready = bus.req_we | credit_s;
        sram_ce       = bus.req_valid & (bus.req_we | credit_s);
        sram_we       = bus.req_we;
        sram_wmask    = bus.req_wmask;
        sram_addr     = bus.req_addr;
        sram_din      = bus.req_wdata;
      end
      default: begin
        bus.req_ready = 1'b0;
      end
    endcase
  end

  assign init_done      = (state_r == ST_IDLE);
  assign rd_fire_s      = sram_ce & ~sram_we & (state_r == ST_IDLE);
  assign bus.resp_valid = (q_count_r != 2'd0);
  assign bus.resp_rdata = q_mem_r[rd_ptr_r];
  assign pop_s          = bus.resp_valid & bus.resp_ready;

  // Response queue: capture macro dout the cycle after a read fires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_r <= 1'b0;
      q_count_r    <= 2'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      q_mem_r[0]   <= {DATA_WIDTH{1'b0}};
      q_mem_r[1]   <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_pending_r <= rd_fire_s;
      if (rd_pending_r) begin
        q_mem_r[wr_ptr_r] <= sram_dout;
        wr_ptr_r          <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({rd_pending_r, pop_s})
        2'b10:   q_count_r <= q_count_r + 2'd1;
        2'b01:   q_count_r <= q_count_r - 2'd1;
        default: q_count_r <= q_count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Randomized self-checking bench for sram22_req_ctrl: a behavioural macro plus a
// reference model (word array, response queue, outstanding-read credit count).
module tb_sram22_req_ctrl;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int MW    = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram22_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) bus ();
  sram22_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) bus1 ();

  logic          init_done, sram_rstb, sram_ce, sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
  logic          init_done1, sram_rstb1, sram_ce1, sram_we1;
  logic [MW-1:0] sram_wmask1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_din1, sram_dout1;
  assign sram_dout1 = 32'h0;

  sram22_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .INIT_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_done(init_done), .sram_rstb(sram_rstb),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout));

  sram22_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .INIT_ON_RESET(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .init_done(init_done1), .sram_rstb(sram_rstb1),
    .sram_ce(sram_ce1), .sram_we(sram_we1), .sram_wmask(sram_wmask1), .sram_addr(sram_addr1),
    .sram_din(sram_din1), .sram_dout(sram_dout1));

  // Behavioural macro: byte-masked write, registered read
  logic [DW-1:0] smem [DEPTH];
  always @(posedge clk) begin
    if (!sram_rstb) begin
      sram_dout <= 32'h0;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask[b]) smem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= smem[sram_addr];
      end
    end
  end

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] pend_d;
  logic          pend_v;
  logic          dut_fire;
  int            outstanding;
  int            cyc;
  int            n_cmp;
  int            n_mis;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus, checks before the edge, model update at the edge
  task automatic cycle(input logic r, input logic v, input logic we, input logic [3:0] m,
                       input logic [7:0] a, input logic [31:0] d, input logic rr);
    logic idle, exp_rdy, exp_rv, fire, pop;
    @(negedge clk);
    rst = r;
    bus.req_valid = v; bus.req_we = we; bus.req_wmask = m;
    bus.req_addr = a; bus.req_wdata = d; bus.resp_ready = rr;
    if (r) begin
      exp_q.delete();
      outstanding = 0;
      pend_v = 1'b0;
      cyc = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    end
    #1;
    idle    = !r && (cyc >= DEPTH + 1);
    exp_rdy = idle && (we || outstanding < 2);
    exp_rv  = (exp_q.size() != 0);
    fire    = v && exp_rdy;
    pop     = exp_rv && rr;
    dut_fire = v && bus.req_ready;
    check_val("req_ready", bus.req_ready, exp_rdy);
    check_val("resp_valid", bus.resp_valid, exp_rv);
    check_val("init_done", init_done, idle);
    check_val("sram_rstb", sram_rstb, !r && cyc >= 1);
    if (exp_rv) check_val("resp_rdata", bus.resp_rdata, exp_q[0]);
    if (r) begin
      check_val("rst_rdata", bus.resp_rdata, 32'h0);
      check_val("rst_ce", sram_ce, 1'b0);
      check_val("rst_we", sram_we, 1'b0);
      check_val("rst_wmask", sram_wmask, 4'h0);
      check_val("rst_addr", sram_addr, 8'h0);
      check_val("rst_din", sram_din, 32'h0);
    end else if (cyc == 0) begin
      check_val("rstwait_ce", sram_ce, 1'b0);
    end else if (cyc <= DEPTH) begin
      check_val("init_ce", sram_ce, 1'b1);
      check_val("init_we", sram_we, 1'b1);
      check_val("init_wmask", sram_wmask, 4'hF);
      check_val("init_din", sram_din, 32'h0);
      check_val("init_addr", sram_addr, 32'(cyc - 1));
    end else begin
      check_val("idle_ce", sram_ce, fire);
      if (fire) begin
        check_val("idle_we", sram_we, we);
        check_val("idle_addr", sram_addr, a);
        if (we) begin
          check_val("idle_wmask", sram_wmask, m);
          check_val("idle_din", sram_din, d);
        end
      end
    end
    check_val("noinit_done", init_done1, !r && cyc >= 1);
    check_val("noinit_ready", bus1.req_ready, !r && cyc >= 1);
    check_val("noinit_ce", sram_ce1, 1'b0);
    @(posedge clk);
    if (!r) begin
      if (pop) void'(exp_q.pop_front());
      if (pend_v) exp_q.push_back(pend_d);
      pend_v = fire && !we;
      if (fire && !we) pend_d = ref_mem[a];
      if (fire && we)
        for (int b = 0; b < MW; b++)
          if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      outstanding = outstanding + int'(fire && !we) - int'(pop);
      if (cyc < 100000) cyc++;
    end
  endtask

  task automatic nop(input logic rr);
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, rr);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    cycle(1'b0, 1'b1, 1'b1, m, a, d, 1'b1);
  endtask

  task automatic rd(input logic [7:0] a, input logic rr);
    cycle(1'b0, 1'b1, 1'b0, 4'h0, a, 32'h0, rr);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; cyc = 0; outstanding = 0; pend_v = 1'b0; pend_d = 32'h0;
    for (int i = 0; i < DEPTH; i++) smem[i] = 32'hA5A5A5A5;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_wmask = 4'h0;
    bus.req_addr = 8'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_wmask = 4'h0;
    bus1.req_addr = 8'h0; bus1.req_wdata = 32'h0; bus1.resp_ready = 1'b1;

    // Reset, zero-fill, then a read of a filled location
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1);
    repeat (DEPTH + 1) nop(1'b1);
    rd(8'h80, 1'b1);
    repeat (3) nop(1'b1);

    // Masked write merge
    wr(8'h12, 32'hDEADBEEF, 4'hF);
    wr(8'h12, 32'h11223344, 4'b0101);
    rd(8'h12, 1'b1);
    repeat (3) nop(1'b1);

    // Backpressure: two reads accepted, third stalls, a write still proceeds
    wr(8'h01, 32'h0000_0A01, 4'hF);
    wr(8'h02, 32'h0000_0A02, 4'hF);
    wr(8'h03, 32'h0000_0A03, 4'hF);
    rd(8'h01, 1'b0);
    rd(8'h02, 1'b0);
    repeat (2) rd(8'h03, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 4'hF, 8'h40, 32'h1234_5678, 1'b0);
    for (int k = 0; k < 10; k++) begin
      rd(8'h03, 1'b1);
      if (dut_fire) break;
      if (k == 9) check_val("rd3_accept_timeout", 32'(dut_fire), 32'h1);
    end
    repeat (4) nop(1'b1);
    rd(8'h40, 1'b1);
    repeat (3) nop(1'b1);

    // Read immediately after write to the same word
    wr(8'h05, 32'hCAFEF00D, 4'hF);
    rd(8'h05, 1'b1);
    repeat (3) nop(1'b1);

    // Random traffic over a small address window to force collisions
    repeat (600) begin
      cycle(1'b0, $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
            8'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
    end
    repeat (4) nop(1'b1);

    // Reset with a queued response, then a second reset mid zero-fill
    rd(8'h12, 1'b0);
    repeat (2) nop(1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    repeat (8'h41) nop(1'b1);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1);
    repeat (DEPTH + 1) nop(1'b1);
    rd(8'h12, 1'b1);
    rd(8'h03, 1'b1);
    repeat (4) nop(1'b1);
    repeat (100) begin
      cycle(1'b0, 1'($urandom), 1'($urandom), 4'($urandom),
            8'($urandom_range(0, 7)), $urandom, 1'($urandom));
    end
    repeat (4) nop(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
